rr_sel_arb: RTL and testbench

Round-robin arbiter and capture stage that drives the 2-bit select of the 4:1 data mux and consumes its output. Four requesters raise level requests. The block grants one requester at a time, steers the mux select to it, and registers the mux output one cycle later. It then presents the captured word downstream with a valid/ready handshake and acknowledges the granted requester once the word is accepted.

---
 rtl/rr_sel_arb.sv | 119 +++++++++++
 tb/tb_rr_sel_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_arb.sv
// Round-robin arbiter for four requesters. It steers the select of an external
// 4:1 mux, captures the mux output, and hands the word downstream with valid/ready.
module rr_sel_arb #(
    parameter int w = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [3:0]   req,
    input  logic [w-1:0] mux_o,
    output logic [1:0]   s,
    output logic [3:0]   gnt,
    output logic [3:0]   ack,
    output logic [w-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [1:0]     ptr_r, ptr_s;
    logic [1:0]     s_s;
    logic [3:0]     gnt_s;
    logic [3:0]     ack_s;
    logic [w-1:0]   out_data_s;
    logic           out_valid_s;
    logic [1:0]     win_s;

    // First set request bit, searching upward from the pointer with wrap-around.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        logic [1:0] res;
        res   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + i[1:0];
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    assign win_s = rr_pick(req, ptr_r);

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        s_s         = s;
        gnt_s       = gnt;
        ack_s       = 4'b0000;
        out_data_s  = out_data;
        out_valid_s = out_valid;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    s_s     = win_s;
                    gnt_s   = 4'b0001 << win_s;
                    state_s = ST_SEL;
                end else begin
                    gnt_s   = 4'b0000;
                end
            end
            ST_SEL: begin
                // The mux has had one full cycle to settle on the new select.
                out_data_s  = mux_o;
                out_valid_s = 1'b1;
                state_s     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_s = 1'b0;
                    gnt_s       = 4'b0000;
                    ack_s       = gnt;
                    ptr_s       = s + 2'd1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s     = ST_HOLD;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                gnt_s       = 4'b0000;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 2'd0;
            s         <= 2'd0;
            gnt       <= 4'b0000;
            ack       <= 4'b0000;
            out_data  <= {w{1'b0}};
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            s         <= s_s;
            gnt       <= gnt_s;
            ack       <= ack_s;
            out_data  <= out_data_s;
            out_valid <= out_valid_s;
        end
    end

endmodule

// File: tb/tb_rr_sel_arb.sv
// Bench for rr_sel_arb: transaction-level reference model feeding a scoreboard,
// directed scenarios followed by randomized requests, backpressure and resets.
module tb_rr_sel_arb;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] mux_o;
    logic [1:0]   s;
    logic [3:0]   gnt, ack;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] d [4];

    rr_sel_arb #(.w(W)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .mux_o(mux_o), .s(s), .gnt(gnt),
        .ack(ack), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    assign mux_o = d[s];

    typedef struct packed {
        logic [1:0]   s;
        logic [3:0]   gnt;
        logic [3:0]   ack;
        logic [W-1:0] data;
        logic         valid;
    } snap_t;
    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] data;
    } txn_t;

    snap_t exp_q[$];
    txn_t  txn_q[$];
    int    tests = 0;
    int    fails = 0;
    int    m_phase = 0;   // 0 idle, 1 select settling, 2 word offered
    int    m_ptr = 0;
    snap_t m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances one clock per rising edge from the bench's own inputs.
    always @(posedge clk) begin
        if (!rst_b) begin
            m_phase = 0;
            m_ptr   = 0;
            m       = '0;
            txn_q.delete();
        end else begin
            m.ack = 4'b0000;
            if (m_phase == 0) begin
                if (req != 4'b0000) begin
                    int pick;
                    pick = -1;
                    for (int k = 0; k < 4; k++) begin
                        if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
                    end
                    m.s     = 2'(pick);
                    m.gnt   = 4'(1 << pick);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m.data  = d[m.s];
                m.valid = 1'b1;
                txn_q.push_back({m.s, m.data});
                m_phase = 2;
            end else begin
                if (out_ready) begin
                    m.ack   = m.gnt;
                    m.gnt   = 4'b0000;
                    m.valid = 1'b0;
                    m_ptr   = (int'(m.s) + 1) % 4;
                    m_phase = 0;
                end
            end
        end
        exp_q.push_back(m);
    end

    // Monitor: compares every cycle's outputs and every acknowledged word.
    always @(negedge clk) begin
        snap_t e;
        txn_t  t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("s", 32'(s), 32'(e.s));
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("ack", 32'(ack), 32'(e.ack));
            chk("out_valid", 32'(out_valid), 32'(e.valid));
            chk("out_data", 32'(out_data), 32'(e.data));
        end
        if (ack != 4'b0000) begin
            if (txn_q.size() == 0) begin
                chk("ack_without_txn", 32'(ack), 32'd0);
            end else begin
                t = txn_q.pop_front();
                chk("txn_ack", 32'(ack), 32'(4'b0001 << t.idx));
                chk("txn_data", 32'(out_data), 32'(t.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (m_phase != p && n < 30) begin
            step();
            n++;
        end
        if (m_phase != p) begin
            fails++;
            $display("FAIL wait_phase: got %0d expected %0d", m_phase, p);
        end
    endtask

    initial begin
        d[0] = 4'd1; d[1] = 4'd5; d[2] = 4'd7; d[3] = 4'd9;
        repeat (2) step();
        rst_b = 1'b1;

        // Single request after reset
        req = 4'b0010; out_ready = 1'b1;
        step();
        req = 4'b0000;
        repeat (4) step();

        // Round-robin rotation from a fresh pointer
        rst_b = 1'b0; step(); rst_b = 1'b1;
        req = 4'b1111;
        repeat (15) step();
        req = 4'b0000;
        repeat (4) step();

        // Backpressure with the mux input changing underneath
        out_ready = 1'b0; d[2] = 4'd7; req = 4'b0100;
        wait_phase(2);
        req = 4'b0000;
        repeat (5) step();
        d[2] = 4'd3;
        repeat (5) step();
        out_ready = 1'b1;
        repeat (3) step();

        // Request dropped while the select is settling
        d[3] = 4'd11; req = 4'b1000;
        wait_phase(1);
        req = 4'b0000;
        repeat (4) step();

        // Reset while the word is held
        out_ready = 1'b0; req = 4'b1001;
        wait_phase(2);
        rst_b = 1'b0; step(); rst_b = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();
        req = 4'b0000;

        // Long idle stretch
        repeat (20) step();

        // Randomized traffic
        repeat (400) begin
            req       = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            d[$urandom_range(0, 3)] = W'($urandom);
            rst_b     = ($urandom_range(0, 63) != 0);
            step();
        end
        rst_b = 1'b1; req = 4'b0000; out_ready = 1'b1;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
